// File: rtl/gray_counter_if.sv
// Purpose: bundles the control inputs and the count outputs of gray_counter.
// Latency: not applicable; this is wiring only.
// Backpressure: none; the counter accepts a command every cycle.
//
// Signals:
//   en, dir, load, load_bin : driven by the master toward the counter
//   gray, bin, wrap         : driven by the counter toward the master
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;
    logic             wrap;

    modport master (
        output en, dir, load, load_bin,
        input  gray, bin, wrap
    );

    modport slave (
        input  en, dir, load, load_bin,
        output gray, bin, wrap
    );
endinterface

// File: rtl/gray_counter.sv
// Purpose: registered WIDTH-bit Gray counter with a binary shadow count, sync load, wrap/saturate.
// Latency: one cycle from sampled inputs to bin/gray/wrap; no combinational input-to-output path.
// Backpressure: none; a step, load or reset is accepted every cycle.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous, active-high reset (bin = INIT, gray = Gray(INIT), wrap = 0)
//   bus.en           step enable
//   bus.dir          1 = up, 0 = down (honoured only when GRAY_DOWN_EN is defined)
//   bus.load         synchronous load of bus.load_bin (beats en)
//   bus.load_bin     binary value to load
//   bus.gray         registered Gray code of the count
//   bus.bin          registered binary count
//   bus.wrap         one-cycle pulse following a terminal step (wrapped or blocked)
//
// Build option: define GRAY_DOWN_EN to enable down stepping; otherwise the
// counter is up-only and no decrement logic is built.
module gray_counter #(
    parameter int WIDTH = 4,
    parameter int INIT  = 0,
    parameter bit WRAP  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    gray_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] INIT_BIN  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
    localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO  = {WIDTH{1'b0}};

    logic [WIDTH-1:0] bin_q,  bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             step_up;

    always_comb begin
`ifdef GRAY_DOWN_EN
        step_up = bus.dir;
`else
        step_up = 1'b1;
`endif
    end

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_bin;
        end else if (bus.en) begin
            if (step_up) begin
                // Terminal test is against all-ones, not a carry-out of a wider add.
                if (bin_q == ALL_ONES) begin
                    wrap_d = 1'b1;
                    bin_d  = WRAP ? ALL_ZERO : bin_q;
                end else begin
                    bin_d = bin_q + 1'b1;
                end
            end
`ifdef GRAY_DOWN_EN
            else begin
                if (bin_q == ALL_ZERO) begin
                    wrap_d = 1'b1;
                    bin_d  = WRAP ? ALL_ONES : bin_q;
                end else begin
                    bin_d = bin_q - 1'b1;
                end
            end
`endif
        end
        // Gray comes from the same next value as bin, so the gray register
        // only ever changes as one clean registered update.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= INIT_BIN;
            gray_q <= INIT_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.bin  = bin_q;
    assign bus.gray = gray_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_gray_counter.sv
// Purpose: directed self-checking bench for gray_counter (widths 2, 4, 8; wrap and saturate).
// Latency: expects outputs one clock after inputs are sampled.
// Backpressure: none.
module tb_gray_counter;
    logic clk;
    logic rst;
    int   checks;
    int   passes;

    gray_counter_if #(.WIDTH(4)) if4  ();
    gray_counter_if #(.WIDTH(4)) if4s ();
    gray_counter_if #(.WIDTH(2)) if2  ();
    gray_counter_if #(.WIDTH(8)) if8  ();

    gray_counter #(.WIDTH(4), .INIT(0), .WRAP(1'b1)) u_c4  (.clk(clk), .rst(rst), .bus(if4));
    gray_counter #(.WIDTH(4), .INIT(0), .WRAP(1'b0)) u_c4s (.clk(clk), .rst(rst), .bus(if4s));
    gray_counter #(.WIDTH(2), .INIT(0), .WRAP(1'b1)) u_c2  (.clk(clk), .rst(rst), .bus(if2));
    gray_counter #(.WIDTH(8), .INIT(0), .WRAP(1'b1)) u_c8  (.clk(clk), .rst(rst), .bus(if8));

    // Hand-written Gray codes for 4-bit values 0..15.
    logic [3:0] gray4_tab [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };
    logic [1:0] gray2_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    // Advance one edge and sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        if4.en = 1'b1; if4s.en = 1'b1; if2.en = 1'b1; if8.en = 1'b1;
        do_reset();
        if4.en = 1'b0; if4s.en = 1'b0; if2.en = 1'b0; if8.en = 1'b0;
        checks++;
        if ({if4.bin, if4.gray, if4.wrap} !== {4'd0, 4'b0000, 1'b0})
            $display("FAIL reset_w4: got bin=%0d gray=%b wrap=%b, want 0 0000 0", if4.bin, if4.gray, if4.wrap);
        else passes++;
        checks++;
        if ({if4s.bin, if4s.gray, if4s.wrap} !== {4'd0, 4'b0000, 1'b0})
            $display("FAIL reset_w4s: got bin=%0d gray=%b wrap=%b, want 0 0000 0", if4s.bin, if4s.gray, if4s.wrap);
        else passes++;
        checks++;
        if ({if2.bin, if2.gray, if2.wrap, if8.bin, if8.gray, if8.wrap} !== {2'd0, 2'd0, 1'b0, 8'd0, 8'd0, 1'b0})
            $display("FAIL reset_w2w8: got w2 bin=%0d gray=%b w8 bin=%0d gray=%b, want zeros", if2.bin, if2.gray, if8.bin, if8.gray);
        else passes++;
    endtask

    task automatic test_count();
        logic [3:0] prev_gray;
        logic [3:0] eb;
        logic [3:0] diff;
        prev_gray = if4.gray;
        if4.en  = 1'b1;
        if4.dir = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            eb = 4'((i + 1) % 16);
            checks++;
            if ({if4.bin, if4.gray, if4.wrap} !== {eb, gray4_tab[eb], (i == 15)})
                $display("FAIL count_step%0d: got bin=%0d gray=%b wrap=%b, want bin=%0d gray=%b wrap=%b",
                         i, if4.bin, if4.gray, if4.wrap, eb, gray4_tab[eb], (i == 15));
            else passes++;
            diff = if4.gray ^ prev_gray;
            checks++;
            if (($countones(diff) != 1) || (if4.gray !== (if4.bin ^ (if4.bin >> 1))))
                $display("FAIL count_onebit%0d: got gray=%b prev=%b bin=%0d, want one-bit change and invariant",
                         i, if4.gray, prev_gray, if4.bin);
            else passes++;
            prev_gray = if4.gray;
        end
        if4.en = 1'b0;
    endtask

    task automatic test_saturation();
        logic [3:0] exp_bin  [3] = '{4'd15, 4'd15, 4'd15};
        logic       exp_wrap [3] = '{1'b0, 1'b1, 1'b1};
        if4s.load     = 1'b1;
        if4s.load_bin = 4'd14;
        tick();
        if4s.load = 1'b0;
        checks++;
        if ({if4s.bin, if4s.gray, if4s.wrap} !== {4'd14, 4'b1001, 1'b0})
            $display("FAIL sat_load: got bin=%0d gray=%b wrap=%b, want 14 1001 0", if4s.bin, if4s.gray, if4s.wrap);
        else passes++;
        if4s.en  = 1'b1;
        if4s.dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({if4s.bin, if4s.gray, if4s.wrap} !== {exp_bin[i], 4'b1000, exp_wrap[i]})
                $display("FAIL sat_step%0d: got bin=%0d gray=%b wrap=%b, want %0d 1000 %b",
                         i, if4s.bin, if4s.gray, if4s.wrap, exp_bin[i], exp_wrap[i]);
            else passes++;
        end
        if4s.en = 1'b0;
    endtask

`ifdef GRAY_DOWN_EN
    task automatic test_down_wrap();
        logic [3:0] exp_bin  [3] = '{4'd0, 4'd15, 4'd14};
        logic [3:0] exp_gray [3] = '{4'b0000, 4'b1000, 4'b1001};
        logic       exp_wrap [3] = '{1'b0, 1'b1, 1'b0};
        if4.load     = 1'b1;
        if4.load_bin = 4'd1;
        tick();
        if4.load = 1'b0;
        if4.en   = 1'b1;
        if4.dir  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({if4.bin, if4.gray, if4.wrap} !== {exp_bin[i], exp_gray[i], exp_wrap[i]})
                $display("FAIL down_step%0d: got bin=%0d gray=%b wrap=%b, want %0d %b %b",
                         i, if4.bin, if4.gray, if4.wrap, exp_bin[i], exp_gray[i], exp_wrap[i]);
            else passes++;
        end
        if4.en  = 1'b0;
        if4.dir = 1'b1;
    endtask
`else
    task automatic test_up_only();
        if4.load     = 1'b1;
        if4.load_bin = 4'd1;
        tick();
        if4.load = 1'b0;
        if4.en   = 1'b1;
        if4.dir  = 1'b0;
        tick();
        checks++;
        if ({if4.bin, if4.gray, if4.wrap} !== {4'd2, 4'b0011, 1'b0})
            $display("FAIL uponly_step0: got bin=%0d gray=%b wrap=%b, want 2 0011 0", if4.bin, if4.gray, if4.wrap);
        else passes++;
        tick();
        checks++;
        if ({if4.bin, if4.gray, if4.wrap} !== {4'd3, 4'b0010, 1'b0})
            $display("FAIL uponly_step1: got bin=%0d gray=%b wrap=%b, want 3 0010 0", if4.bin, if4.gray, if4.wrap);
        else passes++;
        if4.en  = 1'b0;
        if4.dir = 1'b1;
    endtask
`endif

    task automatic test_priority();
        if4.load     = 1'b1;
        if4.load_bin = 4'd15;
        tick();
        // Load and a terminal up-step in the same cycle: load wins, no wrap.
        if4.load_bin = 4'd5;
        if4.en       = 1'b1;
        if4.dir      = 1'b1;
        tick();
        if4.load = 1'b0;
        checks++;
        if ({if4.bin, if4.gray, if4.wrap} !== {4'd5, 4'b0111, 1'b0})
            $display("FAIL prio_load: got bin=%0d gray=%b wrap=%b, want 5 0111 0", if4.bin, if4.gray, if4.wrap);
        else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({if4.bin, if4.gray, if4.wrap} !== {4'd0, 4'b0000, 1'b0})
            $display("FAIL prio_rst: got bin=%0d gray=%b wrap=%b, want 0 0000 0", if4.bin, if4.gray, if4.wrap);
        else passes++;
        tick();
        checks++;
        if ({if4.bin, if4.gray, if4.wrap} !== {4'd1, 4'b0001, 1'b0})
            $display("FAIL prio_after_rst: got bin=%0d gray=%b wrap=%b, want 1 0001 0", if4.bin, if4.gray, if4.wrap);
        else passes++;
        if4.en = 1'b0;
    endtask

    task automatic test_hold();
        if4.load     = 1'b1;
        if4.load_bin = 4'd9;
        tick();
        if4.load = 1'b0;
        if4.en   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if4.dir      = 1'($urandom_range(0, 1));
            if4.load_bin = 4'($urandom_range(0, 15));
            tick();
            checks++;
            if ({if4.bin, if4.gray, if4.wrap} !== {4'd9, 4'b1101, 1'b0})
                $display("FAIL hold%0d: got bin=%0d gray=%b wrap=%b, want 9 1101 0", i, if4.bin, if4.gray, if4.wrap);
            else passes++;
        end
        if4.dir = 1'b1;
    endtask

    task automatic test_width_sweep();
        logic [1:0] eb2;
        logic [7:0] eb8;
        logic [7:0] eg8;
        int         wraps;
        do_reset();
        if2.en  = 1'b1;
        if2.dir = 1'b1;
        wraps = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            eb2 = 2'((i + 1) % 4);
            if (if2.wrap === 1'b1) wraps++;
            checks++;
            if ({if2.bin, if2.gray, if2.wrap} !== {eb2, gray2_tab[eb2], (i == 3)})
                $display("FAIL w2_step%0d: got bin=%0d gray=%b wrap=%b, want %0d %b %b",
                         i, if2.bin, if2.gray, if2.wrap, eb2, gray2_tab[eb2], (i == 3));
            else passes++;
        end
        if2.en = 1'b0;
        checks++;
        if (wraps != 1)
            $display("FAIL w2_wrap_count: got %0d pulses, want 1", wraps);
        else passes++;

        if8.en  = 1'b1;
        if8.dir = 1'b1;
        wraps = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            eb8 = 8'((i + 1) % 256);
            eg8 = eb8 ^ (eb8 >> 1);
            if (if8.wrap === 1'b1) wraps++;
            checks++;
            if ({if8.bin, if8.gray, if8.wrap} !== {eb8, eg8, (i == 255)})
                $display("FAIL w8_step%0d: got bin=%0d gray=%b wrap=%b, want %0d %b %b",
                         i, if8.bin, if8.gray, if8.wrap, eb8, eg8, (i == 255));
            else passes++;
        end
        if8.en = 1'b0;
        checks++;
        if (wraps != 1)
            $display("FAIL w8_wrap_count: got %0d pulses, want 1", wraps);
        else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rst = 1'b0;
        if4.en = 1'b0;  if4.dir = 1'b1;  if4.load = 1'b0;  if4.load_bin = '0;
        if4s.en = 1'b0; if4s.dir = 1'b1; if4s.load = 1'b0; if4s.load_bin = '0;
        if2.en = 1'b0;  if2.dir = 1'b1;  if2.load = 1'b0;  if2.load_bin = '0;
        if8.en = 1'b0;  if8.dir = 1'b1;  if8.load = 1'b0;  if8.load_bin = '0;
        @(negedge clk);

        test_reset();
        test_count();
        test_saturation();
`ifdef GRAY_DOWN_EN
        test_down_wrap();
`else
        test_up_only();
`endif
        test_priority();
        test_hold();
        test_width_sweep();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
